// File: rtl/ctrl_trace_encoder_pkg.sv
// Shared definitions for the retire-side trace encoder: class codes, record
// field layout and counter widths.
package ctrl_trace_encoder_pkg;

   localparam logic [3:0] CLS_ALU      = 4'h0;
   localparam logic [3:0] CLS_LOAD     = 4'h1;
   localparam logic [3:0] CLS_LB       = 4'h2;
   localparam logic [3:0] CLS_STORE    = 4'h3;
   localparam logic [3:0] CLS_BEQ      = 4'h4;
   localparam logic [3:0] CLS_BNE      = 4'h5;
   localparam logic [3:0] CLS_BLTZ     = 4'h6;
   localparam logic [3:0] CLS_JMP      = 4'h7;
   localparam logic [3:0] CLS_JAL      = 4'h8;
   localparam logic [3:0] CLS_JR       = 4'h9;
   localparam logic [3:0] CLS_SRAV     = 4'hA;
   localparam logic [3:0] CLS_NOP      = 4'hE;
   localparam logic [3:0] CLS_SYSCALL  = 4'hF;

   localparam int REC_W        = 32;
   localparam int REC_CLS_LSB  = 28;
   localparam int REC_CLS_W    = 4;
   localparam int REC_ALU_LSB  = 24;
   localparam int REC_ALU_W    = 4;
   localparam int REC_TKN_BIT  = 23;
   localparam int REC_SEQ_LSB  = 16;
   localparam int SEQ_W        = 7;
   localparam int REC_PC_LSB   = 0;
   localparam int REC_PC_W     = 16;
   localparam int DROP_W       = 8;

   // Control-flow classes are the ones kept when the trace filter is on.
   function automatic logic is_ctrl_flow(input logic [3:0] cls);
      return ((cls >= CLS_BEQ) && (cls <= CLS_JR)) || (cls == CLS_SYSCALL);
   endfunction

endpackage

// File: rtl/ctrl_trace_encoder_trace_fifo.sv
// Synchronous single-clock FIFO with a registered head output; it knows
// nothing about the data it carries.
module ctrl_trace_encoder_trace_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_nxt;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign level   = count;
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign do_push = push & (~full | do_pop);
   assign rd_nxt  = rd_ptr + AW'(1);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_nxt;
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         // rd_data always mirrors the entry that will sit at rd_ptr after this edge.
         if (empty && do_push) begin
            rd_data <= wr_data;
         end else if (do_pop) begin
            if (count > (AW+1)'(1)) rd_data <= mem[rd_nxt];
            else if (do_push)       rd_data <= wr_data;
         end
      end
   end

endmodule

// File: rtl/ctrl_trace_encoder.sv
// Re-encodes retiring control strobes into compact 32-bit trace records and
// queues them for the board debug port. Define TRACE_FILTER_EN to keep only control flow.
module ctrl_trace_encoder
   import ctrl_trace_encoder_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     Valid,
   input  logic [31:0]              PC,
   input  logic [3:0]               ALU_OP,
   input  logic                     RegWrite,
   input  logic                     MemToReg,
   input  logic                     MemWrite,
   input  logic                     LB,
   input  logic                     SRAV,
   input  logic                     Beq,
   input  logic                     Bne,
   input  logic                     BLTZ,
   input  logic                     JMP,
   input  logic                     JAL,
   input  logic                     JR,
   input  logic                     SysCALL,
   input  logic                     Taken,
   input  logic                     TrReady,
   output logic                     TrValid,
   output logic [31:0]              TrData,
   output logic [DROP_W-1:0]        DropCnt,
   output logic [$clog2(DEPTH):0]   Level
);

   // TrValid/TrReady: a record transfers on every edge where both are high;
   // TrData holds steady while TrValid is high and TrReady is low.

   logic [3:0]        cls;
   logic              pass;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              drop;
   logic              taken_bit;
   logic [SEQ_W-1:0]  seq;
   logic [REC_W-1:0]  record;
   logic              unused_pc;

   always_comb begin
      if      (SysCALL)  cls = CLS_SYSCALL;
      else if (JR)       cls = CLS_JR;
      else if (JAL)      cls = CLS_JAL;
      else if (JMP)      cls = CLS_JMP;
      else if (BLTZ)     cls = CLS_BLTZ;
      else if (Bne)      cls = CLS_BNE;
      else if (Beq)      cls = CLS_BEQ;
      else if (MemWrite) cls = CLS_STORE;
      else if (LB)       cls = CLS_LB;
      else if (MemToReg) cls = CLS_LOAD;
      else if (SRAV)     cls = CLS_SRAV;
      else if (RegWrite) cls = CLS_ALU;
      else               cls = CLS_NOP;
   end

`ifdef TRACE_FILTER_EN
   assign pass = is_ctrl_flow(cls);
`else
   assign pass = 1'b1;
`endif

   assign taken_bit = Taken & (Beq | Bne | BLTZ);
   assign record    = {cls, ALU_OP, taken_bit, seq, PC[17:2]};
   assign unused_pc = ^{PC[31:18], PC[1:0]};

   assign fifo_push = Valid & pass;
   assign fifo_pop  = TrValid & TrReady;
   assign drop      = fifo_push & fifo_full & ~fifo_pop;
   assign TrValid   = ~fifo_empty;

   ctrl_trace_encoder_trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .push    (fifo_push),
      .wr_data (record),
      .pop     (fifo_pop),
      .rd_data (TrData),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (Level)
   );

   // Seq advances on every retirement, so filtered or dropped records leave gaps.
   always_ff @(posedge CLK) begin
      if (RST) begin
         seq     <= '0;
         DropCnt <= '0;
      end else begin
         if (Valid) seq <= seq + SEQ_W'(1);
         if (drop && (DropCnt != {DROP_W{1'b1}})) DropCnt <= DropCnt + DROP_W'(1);
      end
   end

endmodule

// File: tb/tb_ctrl_trace_encoder.sv
// Self-checking bench for ctrl_trace_encoder: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_ctrl_trace_encoder;

   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef TRACE_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif

   // strb bit order: 0 RegWrite, 1 SRAV, 2 MemToReg, 3 LB, 4 MemWrite, 5 Beq,
   // 6 Bne, 7 BLTZ, 8 JMP, 9 JAL, 10 JR, 11 SysCALL
   localparam logic [11:0] S_ALU = 12'h001;
   localparam logic [11:0] S_JMP = 12'h100;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          Valid = 1'b0;
   logic          Taken = 1'b0;
   logic          TrReady = 1'b0;
   logic [31:0]   PC = '0;
   logic [3:0]    ALU_OP = '0;
   logic [11:0]   strb = '0;
   logic          TrValid;
   logic [31:0]   TrData;
   logic [7:0]    DropCnt;
   logic [LW-1:0] Level;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_q[$];
   int          m_seq  = 0;
   int          m_drop = 0;

   ctrl_trace_encoder #(.DEPTH(DEPTH)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .Valid    (Valid),
      .PC       (PC),
      .ALU_OP   (ALU_OP),
      .RegWrite (strb[0]),
      .MemToReg (strb[2]),
      .MemWrite (strb[4]),
      .LB       (strb[3]),
      .SRAV     (strb[1]),
      .Beq      (strb[5]),
      .Bne      (strb[6]),
      .BLTZ     (strb[7]),
      .JMP      (strb[8]),
      .JAL      (strb[9]),
      .JR       (strb[10]),
      .SysCALL  (strb[11]),
      .Taken    (Taken),
      .TrReady  (TrReady),
      .TrValid  (TrValid),
      .TrData   (TrData),
      .DropCnt  (DropCnt),
      .Level    (Level)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   function automatic logic [3:0] ref_class(input logic [11:0] s);
      if (s[11]) return 4'hF;
      if (s[10]) return 4'h9;
      if (s[9])  return 4'h8;
      if (s[8])  return 4'h7;
      if (s[7])  return 4'h6;
      if (s[6])  return 4'h5;
      if (s[5])  return 4'h4;
      if (s[4])  return 4'h3;
      if (s[3])  return 4'h2;
      if (s[2])  return 4'h1;
      if (s[1])  return 4'hA;
      if (s[0])  return 4'h0;
      return 4'hE;
   endfunction

   function automatic bit ref_cf(input logic [3:0] c);
      return ((c >= 4'h4) && (c <= 4'h9)) || (c == 4'hF);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One clock: advance the model with the inputs now driven, take the edge,
   // then compare every observable output.
   task automatic step();
      logic [31:0] rec;
      logic [3:0]  c;
      bit          pop;
      if (RST) begin
         exp_q.delete();
         m_seq  = 0;
         m_drop = 0;
      end else begin
         c   = ref_class(strb);
         rec = {c, ALU_OP, Taken & (strb[5] | strb[6] | strb[7]), 7'(m_seq), PC[17:2]};
         pop = (exp_q.size() > 0) && TrReady;
         if (pop) void'(exp_q.pop_front());
         if (Valid && (!FILTER || ref_cf(c))) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(rec);
            else if (m_drop < 255)    m_drop++;
         end
         if (Valid) m_seq = (m_seq + 1) % 128;
      end
      @(posedge CLK);
      #1;
      check("trvalid", 32'(TrValid), 32'(exp_q.size() > 0));
      check("level",   32'(Level),   32'(exp_q.size()));
      check("dropcnt", 32'(DropCnt), 32'(m_drop));
      if (exp_q.size() > 0) check("trdata", TrData, exp_q[0]);
   endtask

   // ---------------- drivers ----------------
   task automatic drive(input logic v, input logic [11:0] s, input logic [3:0] alu,
                        input logic t, input logic [31:0] pc, input logic rdy);
      Valid   = v;
      strb    = s;
      ALU_OP  = alu;
      Taken   = t;
      PC      = pc;
      TrReady = rdy;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
      step();
      RST = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [11:0] s;
      logic        t;
      logic [3:0]  exp_cls;
      logic        exp_tkn;
   } vec_t;

   vec_t vecs[14];

   initial begin
      vecs[0]  = '{12'h001, 1'b1, 4'h0, 1'b0};
      vecs[1]  = '{12'h003, 1'b0, 4'hA, 1'b0};
      vecs[2]  = '{12'h005, 1'b0, 4'h1, 1'b0};
      vecs[3]  = '{12'h00D, 1'b0, 4'h2, 1'b0};
      vecs[4]  = '{12'h010, 1'b1, 4'h3, 1'b0};
      vecs[5]  = '{12'h020, 1'b0, 4'h4, 1'b0};
      vecs[6]  = '{12'h040, 1'b1, 4'h5, 1'b1};
      vecs[7]  = '{12'h080, 1'b1, 4'h6, 1'b1};
      vecs[8]  = '{12'h100, 1'b1, 4'h7, 1'b0};
      vecs[9]  = '{12'h201, 1'b0, 4'h8, 1'b0};
      vecs[10] = '{12'h400, 1'b0, 4'h9, 1'b0};
      vecs[11] = '{12'hFFF, 1'b1, 4'hF, 1'b1};
      vecs[12] = '{12'h000, 1'b1, 4'hE, 1'b0};
      vecs[13] = '{12'h030, 1'b1, 4'h4, 1'b1};

      // Reset state
      do_reset();
      check("rst_trvalid", 32'(TrValid), 32'd0);
      check("rst_trdata",  TrData,       32'd0);
      check("rst_level",   32'(Level),   32'd0);
      check("rst_dropcnt", 32'(DropCnt), 32'd0);

      // First record after reset, visible one cycle later
      drive(1'b1, 12'h020, 4'h6, 1'b1, 32'h0000_3010, 1'b1);
      step();
      check("beq_trvalid", 32'(TrValid), 32'd1);
      check("beq_record",  TrData,       32'h4680_0C04);
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
      step();

      // Class table
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, vecs[i].s, 4'(i), vecs[i].t, 32'h0040_0000 + 32'(i * 4), 1'b0);
         step();
         if (!FILTER || ref_cf(vecs[i].exp_cls)) begin
            check($sformatf("tbl%0d_cls", i), 32'(TrData[31:28]), 32'(vecs[i].exp_cls));
            check($sformatf("tbl%0d_tkn", i), 32'(TrData[23]),    32'(vecs[i].exp_tkn));
            check($sformatf("tbl%0d_seq", i), 32'(TrData[22:16]), 32'(i));
            check($sformatf("tbl%0d_pc",  i), 32'(TrData[15:0]),  32'h0000_0000 + 32'(i));
         end else begin
            check($sformatf("tbl%0d_filtered", i), 32'(Level), 32'd0);
         end
         drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
         step();
      end

      // Overflow: nine pushes into eight entries, then push+pop while full
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, S_JMP, 4'h1, 1'b0, 32'h1000 + 32'(i * 4), 1'b0);
         step();
      end
      check("ovf_level", 32'(Level),   32'd8);
      check("ovf_drop",  32'(DropCnt), 32'd1);
      check("ovf_head_seq", 32'(TrData[22:16]), 32'd0);
      drive(1'b1, S_JMP, 4'h1, 1'b0, 32'h2000, 1'b1);
      step();
      check("full_pp_level", 32'(Level),   32'd8);
      check("full_pp_drop",  32'(DropCnt), 32'd1);
      begin
         int exp_seqs[8] = '{1, 2, 3, 4, 5, 6, 7, 9};
         for (int k = 0; k < 8; k++) begin
            check($sformatf("drain%0d_seq", k), 32'(TrData[22:16]), 32'(exp_seqs[k]));
            drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
            step();
         end
      end
      check("drained_trvalid", 32'(TrValid), 32'd0);

      // Reset with five buffered records and a retirement in the reset cycle
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, S_JMP, 4'h2, 1'b0, 32'h3000 + 32'(i * 4), 1'b0);
         step();
      end
      check("pre_rst_level", 32'(Level),   32'd5);
      check("pre_rst_drop",  32'(DropCnt), 32'd1);
      RST = 1'b1;
      drive(1'b1, S_JMP, 4'h2, 1'b0, 32'h4000, 1'b0);
      step();
      check("midrst_trvalid", 32'(TrValid), 32'd0);
      check("midrst_level",   32'(Level),   32'd0);
      check("midrst_drop",    32'(DropCnt), 32'd0);
      RST = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
      step();
      check("postrst_level", 32'(Level), 32'd0);

      // Seq wrap with a continuously ready consumer
      do_reset();
      for (int i = 0; i < 130; i++) begin
         drive(1'b1, S_JMP, 4'h3, 1'b0, 32'h5000 + 32'(i * 4), 1'b1);
         step();
         check($sformatf("wrap%0d_seq", i), 32'(TrData[22:16]), 32'(i % 128));
      end
      check("wrap_drop", 32'(DropCnt), 32'd0);
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
      step();

`ifdef TRACE_FILTER_EN
      // Only control-flow retirements produce records; Seq still counts all
      do_reset();
      drive(1'b1, S_ALU,   4'h0, 1'b0, 32'h6000, 1'b0); step();
      drive(1'b1, 12'h00D, 4'h0, 1'b0, 32'h6004, 1'b0); step();
      drive(1'b1, 12'h200, 4'h0, 1'b0, 32'h6008, 1'b0); step();
      drive(1'b1, 12'h800, 4'h0, 1'b0, 32'h600C, 1'b0); step();
      check("flt_level",  32'(Level),         32'd2);
      check("flt_cls0",   32'(TrData[31:28]), 32'h8);
      check("flt_seq0",   32'(TrData[22:16]), 32'd2);
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1); step();
      check("flt_cls1",   32'(TrData[31:28]), 32'hF);
      check("flt_seq1",   32'(TrData[22:16]), 32'd3);
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1); step();
`endif

      // Randomized traffic with phases of slow and fast draining
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         logic [11:0] s;
         int          rdy_pct;
         rdy_pct = ((i / 200) % 2 == 0) ? 20 : 80;
         for (int b = 0; b < 12; b++) s[b] = ($urandom_range(0, 3) == 0);
         drive($urandom_range(0, 3) != 0, s, 4'($urandom), 1'($urandom),
               $urandom, $urandom_range(0, 99) < rdy_pct);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ctrl_trace_encoder.md
# ctrl_trace_encoder

Retire-side trace encoder for the single-cycle MIPS core: the inverse of the control decoder. It takes the decoded control strobes of each retiring instruction and re-encodes them into a compact 4-bit instruction class. It packs that class with ALU op, branch outcome, sequence number and PC into 32-bit trace records, buffers them in a small FIFO, and drains them over a valid/ready port to the debug/display logic on the FPGA board.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- CLK  in  1  core clock; all state updates on rising edge.
- RST  in  1  reset; one clock, reset is synchronous and active-high.
- Valid  in  1  an instruction retires this cycle; all strobes below qualified by it.
- PC  in  32  PC of the retiring instruction.
- ALU_OP  in  4  decoded ALU operation.
- RegWrite, MemToReg, MemWrite, LB, SRAV, Beq, Bne, BLTZ, JMP, JAL, JR, SysCALL  in  1 each  decoded control strobes.
- Taken  in  1  branch condition true; meaningful only for Beq/Bne/BLTZ.
- TrReady  in  1  consumer accepts TrData this cycle.
- TrValid  out  1  FIFO non-empty; TrData valid.
- TrData  out  32  head record.
- DropCnt  out  8  records lost to overflow, saturating.
- Level  out  clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Class encoding, first match wins: SysCALL 0xF, JR 0x9, JAL 0x8, JMP 0x7, BLTZ 0x6, Bne 0x5, Beq 0x4, MemWrite 0x3, LB 0x2, MemToReg 0x1, SRAV 0xA, RegWrite 0x0, otherwise 0xE (no architectural effect).
- Record layout:
  - [31:28] class
  - [27:24] ALU_OP
  - [23] Taken & (Beq|Bne|BLTZ), 0 otherwise
  - [22:16] Seq
  - [15:0] PC[17:2]
- Seq: 7-bit counter, value before increment goes into record; increments on every Valid cycle (including filtered or dropped records); wraps 127 -> 0.
- Push: a record is generated on every Valid cycle that passes the filter (see Configuration).
- Pop: TrValid & TrReady.
- Full FIFO, push without pop: record dropped; DropCnt increments, saturates at 255.
- Full FIFO, push with simultaneous pop: push accepted, no drop, Level unchanged.
- Empty FIFO, push with TrReady high: no bypass; the record appears the next cycle.
- Strobes are ignored when Valid=0; Seq is unchanged.

## Timing
- Reset values: TrValid 0, TrData 0, DropCnt 0, Level 0, Seq 0, FIFO pointers 0. FIFO contents are don't-care but masked by TrValid.
- RST mid-operation: buffered records are discarded the same edge; a Valid asserted in the reset cycle is ignored.
- Latency: Valid in cycle N -> record written at end of N -> TrValid=1 and TrData=record in N+1 if FIFO was empty.
- TrData is registered head-of-FIFO; it is stable while TrValid=1 and TrReady=0.
- Throughput: one push and one pop per cycle sustained.
- Level updates the edge after push/pop.

## Configuration
- TRACE_FILTER_EN defined: only control-flow classes (0x4-0x9, 0xF) are pushed. Other retirements advance Seq only, so gaps in Seq show the skipped count.
- TRACE_FILTER_EN undefined: every Valid retirement pushes a record.

## Structure
- Shared package: the class code constants (CLS_ALU 0x0 ... CLS_SYSCALL 0xF), record field offsets/widths, DropCnt width.
- Sub-module trace_fifo: synchronous single-clock FIFO with DEPTH parameter, push/pop/full/empty/level. Keep it reusable and unaware of record format.
- Top contains the priority encoder, record packing, Seq counter, drop counter.

## Test plan
- Reset, then Valid with Beq=1, Taken=1, ALU_OP=0x6, PC=0x00003010 -> next cycle TrValid=1, TrData=0x46800C04.
- 9 consecutive Valid ALU retirements, DEPTH=8, filter off, TrReady=0 -> Level=8, DropCnt=1. The first pop shows Seq=0; the 8th pop shows Seq=7.
- FIFO full, TrReady=1 and Valid same cycle -> no drop, Level stays 8; the popped record is the oldest one.
- 130 Valid retirements with TrReady=1 -> Seq field wraps 127 -> 0 -> 1; no drops.
- TRACE_FILTER_EN defined: sequence ALU, LB, JAL, SysCALL -> exactly two records, classes 0x8 and 0xF with Seq 2 and 3.
- RST asserted with Level=5 and Valid=1 -> next cycle TrValid=0, Level=0, DropCnt=0; the retirement in the reset cycle is not recorded.
